led_rotate_sequencer: RTL and testbench

LED_ROTATE_SEQUENCER -- requirements
Module: led_rotate_sequencer

---
 rtl/led_seq_pkg.sv | 33 +++
 rtl/led_seq_dwell_timer.sv | 33 +++
 rtl/led_rotate_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_led_rotate_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED rotate sequencer: FSM states,
// sequence-mode encodings and the rotator width.
package led_seq_pkg;

  localparam int LED_W = 16;
  localparam int POS_W = $clog2(LED_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD   = 2'b00;
  localparam mode_t MODE_LEFT   = 2'b01;
  localparam mode_t MODE_RIGHT  = 2'b10;
  localparam mode_t MODE_BOUNCE = 2'b11;

  // One rotator step, modulo LED_W: up=1 moves toward the MSB.
  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] p, input logic up);
    logic [POS_W-1:0] r;
    if (up) begin
      r = p + POS_W'(1);
    end else begin
      r = p - POS_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/led_seq_dwell_timer.sv
// Dwell counter used at bounce ends: load arms it, tick counts down, and
// expired flags the last dwell cycle.
module led_seq_dwell_timer
  import led_seq_pkg::*;
#(
  parameter int CNT_W    = 3,
  parameter int LOAD_VAL = 4
) (
  input  logic clk_div,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expired
);

  logic [CNT_W-1:0] cnt_r;

  // Down-counter, saturating at zero.
  always_ff @(posedge clk_div) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= CNT_W'(LOAD_VAL);
    end else if (tick && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r <= CNT_W'(1));

endmodule

// File: rtl/led_rotate_sequencer.sv
// Sequencer driving a 16-bit LED rotator (hold / left-N / right-N / bounce).
// Define LED_SEQ_PAUSE_EN to add a PAUSE_CYCLES dwell at each bounce end.
module led_rotate_sequencer
  import led_seq_pkg::*;
#(
  parameter int PAUSE_CYCLES = 4,
  parameter int RESET_POS    = 15
) (
  input  logic             clk_div,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [3:0]       steps,
  output logic             en,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             busy,
  output logic             done
);

  if ((PAUSE_CYCLES < 1) || (RESET_POS < 0) || (RESET_POS >= LED_W)) begin : g_param_check
    $error("led_rotate_sequencer: PAUSE_CYCLES must be >= 1 and RESET_POS within the LED range");
  end

  state_e           state_r;
  state_e           state_nxt_s;
  mode_t            mode_r;
  logic [3:0]       steps_r;
  logic [3:0]       run_cnt_r;
  logic [3:0]       last_step_s;
  logic [POS_W-1:0] pos_r;
  logic [POS_W-1:0] pos_nxt_s;
  logic             en_r;
  logic             dir_r;
  logic             busy_r;
  logic             done_r;
  logic             en_nxt_s;
  logic             dir_nxt_s;
  logic             busy_nxt_s;
  logic             done_nxt_s;
  logic             start_ok_s;
  logic             end_hit_s;

  assign start_ok_s  = (state_r == ST_IDLE) && start && !abort;
  // steps=0 wraps to 15 here, which gives the 16-step run.
  assign last_step_s = steps_r - 4'd1;
  assign pos_nxt_s   = en_r ? pos_step(pos_r, dir_r) : pos_r;
  assign end_hit_s   = (dir_r && (pos_nxt_s == POS_W'(LED_W - 1))) ||
                       (!dir_r && (pos_nxt_s == POS_W'(0)));

`ifdef LED_SEQ_PAUSE_EN
  localparam int DWELL_W = (PAUSE_CYCLES < 2) ? 1 : $clog2(PAUSE_CYCLES + 1);

  logic pause_load_s;
  logic pause_tick_s;
  logic pause_expired_s;

  assign pause_load_s = (state_r == ST_RUN) && (state_nxt_s == ST_PAUSE);
  assign pause_tick_s = (state_r == ST_PAUSE);

  led_seq_dwell_timer #(
    .CNT_W    (DWELL_W),
    .LOAD_VAL (PAUSE_CYCLES)
  ) u_dwell (
    .clk_div (clk_div),
    .rst     (rst),
    .load    (pause_load_s),
    .tick    (pause_tick_s),
    .expired (pause_expired_s)
  );
`endif

  // State register plus the latched request and step counter.
  always_ff @(posedge clk_div) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      mode_r    <= MODE_HOLD;
      steps_r   <= 4'd0;
      run_cnt_r <= 4'd0;
      pos_r     <= POS_W'(RESET_POS);
    end else begin
      state_r <= state_nxt_s;
      pos_r   <= pos_nxt_s;
      if (start_ok_s) begin
        mode_r    <= mode;
        steps_r   <= steps;
        run_cnt_r <= 4'd0;
      end else if (state_r == ST_RUN) begin
        run_cnt_r <= run_cnt_r + 4'd1;
      end else begin
        run_cnt_r <= run_cnt_r;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = (mode == MODE_HOLD) ? ST_DONE : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          case (mode_r)
            MODE_LEFT, MODE_RIGHT: begin
              state_nxt_s = (run_cnt_r == last_step_s) ? ST_DONE : ST_RUN;
            end
            MODE_BOUNCE: begin
`ifdef LED_SEQ_PAUSE_EN
              state_nxt_s = end_hit_s ? ST_PAUSE : ST_RUN;
`else
              state_nxt_s = ST_RUN;
`endif
            end
            default: state_nxt_s = ST_DONE;
          endcase
        end
      end
      ST_PAUSE: begin
`ifdef LED_SEQ_PAUSE_EN
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (pause_expired_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
`else
        state_nxt_s = ST_IDLE;
`endif
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Moore outputs for the upcoming state, and the rotate direction.
  always_comb begin
    en_nxt_s   = (state_nxt_s == ST_RUN);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_DONE);
    dir_nxt_s  = dir_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          case (mode)
            MODE_LEFT:   dir_nxt_s = 1'b1;
            MODE_RIGHT:  dir_nxt_s = 1'b0;
            MODE_BOUNCE: dir_nxt_s = (pos_r != POS_W'(LED_W - 1));
            default:     dir_nxt_s = dir_r;
          endcase
        end else begin
          dir_nxt_s = dir_r;
        end
      end
      ST_RUN: begin
        if ((mode_r == MODE_BOUNCE) && end_hit_s) begin
          dir_nxt_s = !dir_r;
        end else begin
          dir_nxt_s = dir_r;
        end
      end
      default: dir_nxt_s = dir_r;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_div) begin
    if (rst) begin
      en_r   <= 1'b0;
      dir_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      en_r   <= en_nxt_s;
      dir_r  <= dir_nxt_s;
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign en   = en_r;
  assign dir  = dir_r;
  assign pos  = pos_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_led_rotate_sequencer.sv
// Directed bench for led_rotate_sequencer: a vector table for the short
// sequences, then hand-written loops for 16-step wrap, abort, bounce and reset.
module tb_led_rotate_sequencer;

  logic       clk_div = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [1:0] mode;
  logic [3:0] steps;
  logic       en;
  logic       dir;
  logic [3:0] pos;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clk_div = ~clk_div;

  led_rotate_sequencer #(
    .PAUSE_CYCLES (4),
    .RESET_POS    (15)
  ) dut (
    .clk_div (clk_div),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .steps   (steps),
    .en      (en),
    .dir     (dir),
    .pos     (pos),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    string      name;
    logic       r;
    logic       s;
    logic       a;
    logic [1:0] m;
    logic [3:0] n;
    logic [3:0] e_pos;
    logic       e_en;
    logic       e_dir;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs [12];

  task automatic step(input logic r, input logic s, input logic a,
                      input logic [1:0] m, input logic [3:0] n);
    rst   = r;
    start = s;
    abort = a;
    mode  = m;
    steps = n;
    @(posedge clk_div);
    @(negedge clk_div);
  endtask

  task automatic check(input string name, input logic [3:0] e_pos, input logic e_en,
                       input logic e_dir, input logic e_busy, input logic e_done);
    checks++;
    if ({pos, en, dir, busy, done} !== {e_pos, e_en, e_dir, e_busy, e_done}) begin
      errors++;
      $display("FAIL %s: got pos=%0d en=%b dir=%b busy=%b done=%b, expected pos=%0d en=%b dir=%b busy=%b done=%b",
               name, pos, en, dir, busy, done, e_pos, e_en, e_dir, e_busy, e_done);
    end
  endtask

  initial begin
    logic [3:0] ep;
    logic       een;
    logic       edir;

    //           name                rst   start abort mode   steps  pos    en    dir   busy  done
    vecs[0]  = '{"reset_a",          1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"reset_b",          1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"idle_after_reset", 1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"right3_start",     1'b0, 1'b1, 1'b0, 2'b10, 4'd3, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"right3_step1",     1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd14, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{"right3_step2",     1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd13, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{"right3_done",      1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{"right3_idle",      1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"start_abort_idle", 1'b0, 1'b1, 1'b1, 2'b01, 4'd5, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"hold_done",        1'b0, 1'b1, 1'b0, 2'b00, 4'd7, 4'd12, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{"hold_idle",        1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{"left16_start",     1'b0, 1'b1, 1'b0, 2'b01, 4'd0, 4'd12, 1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].m, vecs[i].n);
      check(vecs[i].name, vecs[i].e_pos, vecs[i].e_en, vecs[i].e_dir, vecs[i].e_busy, vecs[i].e_done);
    end

    // Left-16 with wrap; a start on the first RUN cycle must be ignored.
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, (k == 1), 1'b0, 2'b10, 4'd1);
      ep = 4'(12 + k);
      check($sformatf("left16_k%0d", k), ep, (k < 16), 1'b1, 1'b1, (k == 16));
    end
    step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    check("left16_idle", 4'd12, 1'b0, 1'b1, 1'b0, 1'b0);

    // Left-8 aborted in the third RUN cycle: three steps taken, no done.
    step(1'b0, 1'b1, 1'b0, 2'b01, 4'd8);
    check("abort_start", 4'd12, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    check("abort_run1", 4'd13, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    check("abort_run2", 4'd14, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b00, 4'd0);
    check("abort_edge", 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    check("abort_no_done", 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);

    // Bounce from pos=15 starts downward.
    step(1'b0, 1'b1, 1'b0, 2'b11, 4'd0);
    check("bounce_start", 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef LED_SEQ_PAUSE_EN
    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
      if (k < 15) begin
        ep = 4'(15 - k); een = 1'b1; edir = 1'b0;
      end else if (k <= 18) begin
        ep = 4'd0; een = 1'b0; edir = 1'b1;
      end else begin
        ep = 4'(k - 19); een = 1'b1; edir = 1'b1;
      end
      check($sformatf("bounce_pause_k%0d", k), ep, een, edir, 1'b1, 1'b0);
    end
`else
    for (int k = 1; k <= 32; k++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
      if (k <= 15) begin
        ep = 4'(15 - k); edir = (k == 15);
      end else if (k <= 30) begin
        ep = 4'(k - 15); edir = (k != 30);
      end else begin
        ep = 4'(45 - k); edir = 1'b0;
      end
      check($sformatf("bounce_k%0d", k), ep, 1'b1, edir, 1'b1, 1'b0);
    end
`endif

    // Reset mid-bounce overrides everything, including a start request.
    step(1'b1, 1'b1, 1'b0, 2'b01, 4'd3);
    check("rst_mid_bounce", 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
    check("idle_after_rst", 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
